// File: rtl/iter_shifter_if.sv
// Start/ready request and done/result bundle for the bit-serial shifter.
// The requester drives start and operands; the shifter returns status and result.
interface iter_shifter_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
);
   logic             start;
   logic [WIDTH-1:0] In;
   logic [CNT_W-1:0] Cnt;
   logic [1:0]       Op;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] Out;

   modport master (
      output start, In, Cnt, Op,
      input  ready, done, Out
   );

   modport slave (
      input  start, In, Cnt, Op,
      output ready, done, Out
   );
endinterface

// File: rtl/iter_shifter.sv
// Bit-serial shifter: one bit position per clock for ror/sll/sra/srl.
// Result register updates only on entry to DONE, which lasts one cycle.
module iter_shifter #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   iter_shifter_if.slave  bus
);
   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] w_step;
   logic             w_ready;
   logic             w_accept;
   logic             w_last;

   assign w_ready  = (r_state != S_SHIFT);
   assign w_accept = bus.start && w_ready;
   assign w_last   = (r_cnt == CNT_W'(1));

   assign bus.ready = w_ready;
   assign bus.done  = (r_state == S_DONE);
   assign bus.Out   = r_out;

   always_comb begin
      w_step = r_data;
      unique case (r_op)
         OP_ROR: w_step = {r_data[0], r_data[WIDTH-1:1]};
         OP_SLL: w_step = {r_data[WIDTH-2:0], 1'b0};
         OP_SRA: w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
         OP_SRL: w_step = {1'b0, r_data[WIDTH-1:1]};
         default: w_step = r_data;
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept)
               w_next = (bus.Cnt == '0) ? S_DONE : S_SHIFT;
            else
               w_next = S_IDLE;
         end
         S_SHIFT: begin
            if (w_last)
               w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Zero-count requests bypass SHIFT and publish the operand directly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_cnt  <= '0;
         r_op   <= '0;
         r_out  <= '0;
      end else if (w_accept) begin
         r_data <= bus.In;
         r_cnt  <= bus.Cnt;
         r_op   <= bus.Op;
         if (bus.Cnt == '0)
            r_out <= bus.In;
      end else if (r_state == S_SHIFT) begin
         r_data <= w_step;
         r_cnt  <= r_cnt - 1'b1;
         if (w_last)
            r_out <= w_step;
      end
   end
endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: vector table, corner sequences
// and randomized requests against an arithmetic reference model.
module tb_iter_shifter;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   iter_shifter_if #(.WIDTH(16), .CNT_W(4)) bus ();

   iter_shifter #(.WIDTH(16), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] in;
      logic [3:0]  cnt;
      logic [1:0]  op;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] in,
                                         input int cnt,
                                         input logic [1:0] op);
      logic [31:0]        dbl;
      logic signed [15:0] s;
      case (op)
         2'b00: begin
            dbl = {in, in} >> cnt;
            return dbl[15:0];
         end
         2'b01: return in << cnt;
         2'b10: begin
            s = in;
            return s >>> cnt;
         end
         default: return in >> cnt;
      endcase
   endfunction

   // Issue one request (from IDLE or DONE) and follow it to its done pulse
   task automatic run_op(input string tag,
                         input logic [15:0] in,
                         input logic [3:0] cnt,
                         input logic [1:0] op,
                         input logic [15:0] exp);
      logic [15:0] prev;
      int          lat;
      prev = bus.Out;
      bus.start = 1'b1;
      bus.In    = in;
      bus.Cnt   = cnt;
      bus.Op    = op;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.In    = 16'($urandom);
      bus.Cnt   = 4'($urandom);
      bus.Op    = 2'($urandom);
      lat = 1;
      check({tag, "_ready_c1"}, 32'(bus.ready), 32'(cnt == 4'd0));
      while (!bus.done && lat < 40) begin
         check({tag, "_out_hold"}, 32'(bus.Out), 32'(prev));
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, lat, 32'(cnt) + 1);
      check({tag, "_out"}, 32'(bus.Out), 32'(exp));
   endtask

   initial begin
      int ndone;
      int lat;
      n_chk  = 0;
      n_fail = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.In    = '0;
      bus.Cnt   = '0;
      bus.Op    = '0;
      #22;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_out", 32'(bus.Out), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      vecs.push_back('{16'h8001, 4'd1,  2'b00, 16'hC000});
      vecs.push_back('{16'h8000, 4'd15, 2'b10, 16'hFFFF});
      vecs.push_back('{16'h8000, 4'd15, 2'b11, 16'h0001});
      vecs.push_back('{16'h1234, 4'd4,  2'b01, 16'h2340});
      vecs.push_back('{16'hBEEF, 4'd0,  2'b00, 16'hBEEF});
      vecs.push_back('{16'h00FF, 4'd8,  2'b00, 16'hFF00});
      vecs.push_back('{16'h0001, 4'd3,  2'b01, 16'h0008});
      vecs.push_back('{16'h0001, 4'd15, 2'b01, 16'h8000});
      vecs.push_back('{16'h8421, 4'd15, 2'b00, 16'h0843});
      vecs.push_back('{16'h7FFF, 4'd15, 2'b10, 16'h0000});
      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].in, vecs[i].cnt,
                vecs[i].op, vecs[i].exp);
         @(posedge clk);
         #1;
      end

      // start held through SHIFT, then back-to-back request in DONE
      bus.start = 1'b1;
      bus.In    = 16'h00FF;
      bus.Cnt   = 4'd8;
      bus.Op    = 2'b00;
      @(posedge clk);
      #1;
      ndone = 0;
      for (int c = 1; c <= 8; c++) begin
         ndone += int'(bus.done);
         bus.In  = 16'($urandom);
         bus.Cnt = 4'($urandom);
         bus.Op  = 2'($urandom);
         @(posedge clk);
         #1;
      end
      check("hs_no_early_done", ndone, 0);
      check("hs_done", 32'(bus.done), 32'd1);
      check("hs_out", 32'(bus.Out), 32'hFF00);
      bus.In  = 16'h0001;
      bus.Cnt = 4'd3;
      bus.Op  = 2'b01;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("b2b_latency", lat, 4);
      check("b2b_out", 32'(bus.Out), 32'h0008);
      @(posedge clk);
      #1;
      check("b2b_idle_done", 32'(bus.done), 32'd0);

      // asynchronous abort during SHIFT
      bus.start = 1'b1;
      bus.In    = 16'hA5A5;
      bus.Cnt   = 4'd10;
      bus.Op    = 2'b11;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("abort_out", 32'(bus.Out), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_ready", 32'(bus.ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #1;
         ndone += int'(bus.done);
      end
      check("abort_no_done", ndone, 0);

      for (int k = 0; k < 1000; k++) begin
         logic [15:0] rin;
         logic [3:0]  rcnt;
         logic [1:0]  rop;
         rin  = 16'($urandom);
         rcnt = 4'($urandom);
         rop  = 2'($urandom);
         run_op("rnd", rin, rcnt, rop, model(rin, int'(rcnt), rop));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Multi-cycle, bit-serial companion to the combinational barrel shifter. It accepts a 16-bit operand, a count and an op code through a start/ready handshake. It shifts or rotates one bit position per clock and reports the result with a one-cycle done pulse. It adds rotate-right, the opposite direction to the barrel shifter's rotate-left, and it is intended for area-constrained datapaths where a multi-cycle shift is acceptable.

Parameters:
WIDTH, 16, operand/result width in bits.
CNT_W, 4, count width in bits; must equal log2(WIDTH).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge
In  input  WIDTH  operand, captured when start is accepted
Cnt  input  CNT_W  shift amount 0..WIDTH-1, captured with In
Op  input  2  00 ror (rotate right), 01 sll, 10 sra, 11 srl; captured with In
ready  output  1  block can accept start this cycle
done  output  1  one-cycle pulse; Out valid and newly updated
Out  output  WIDTH  result register

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - state=IDLE; Out=0; done=0; ready=1; internal data/count/op registers=0.
  - Asserting rst mid-operation aborts the operation immediately; no done pulse is produced.
- States:
  - IDLE: ready=1, done=0.
  - SHIFT: ready=0, done=0.
  - DONE: ready=1, done=1.
- Start acceptance:
  - A start is accepted when start=1 and ready=1 at a rising edge, i.e. in IDLE or DONE, which allows back-to-back requests.
  - On acceptance: data_r<=In, cnt_r<=Cnt, op_r<=Op.
  - If Cnt==0, next state is DONE; otherwise next state is SHIFT.
- start while in SHIFT is ignored; it is not queued and has no effect.
- SHIFT, each edge, one-bit step on data_r:
  - ror: {data_r[0], data_r[WIDTH-1:1]}
  - sll: {data_r[WIDTH-2:0], 1'b0}
  - sra: {data_r[WIDTH-1], data_r[WIDTH-1:1]}
  - srl: {1'b0, data_r[WIDTH-1:1]}
  - cnt_r<=cnt_r-1. When cnt_r==1 at the edge, next state is DONE and Out<=the shifted value.
- Cnt==0 path: the acceptance edge also loads Out<=In.
- DONE lasts exactly one cycle.
  - If start=1 at that edge, the new request is accepted per the rules above.
  - Otherwise the next state is IDLE.
- Latency: with start sampled at edge 0, done is high in the cycle following edge Cnt (Cnt+1 cycles from the start cycle). Cnt=0 gives done in cycle 1; Cnt=15 gives done in cycle 16.
- Out changes only on entry to DONE (or at reset). It holds between operations and during SHIFT.
- In, Cnt and Op are don't-care except on the accepting edge.
- Arithmetic:
  - Results are modulo WIDTH bits; no carry or overflow output.
  - Cnt cannot exceed WIDTH-1 by width.
  - Rotate by any count is lossless.
- Op encodings 01/10/11 match the barrel shifter's sll/sra/srl. Results must equal the barrel shifter for the same In/Cnt.

Test Plan:
- Rotate right: reset; start, In=0x8001, Cnt=1, Op=00 -> done in cycle 2, Out=0xC000; ready=0 during cycle 1 only.
- Arithmetic right: In=0x8000, Cnt=15, Op=10 -> done in cycle 16, Out=0xFFFF. Same operand with Op=11 -> Out=0x0001.
- Zero count: In=0x1234, Cnt=4, Op=01 -> Out=0x2340 in cycle 5. Then In=0xBEEF, Cnt=0, Op=00 -> done in cycle 1, Out=0xBEEF; ready never drops.
- Handshake: start held high during SHIFT of a Cnt=8 request (In=0x00FF, Op=00) -> only one done pulse with Out=0xFF00. start=1 in the DONE cycle with In=0x0001, Cnt=3, Op=01 -> accepted; next done 4 cycles later with Out=0x0008.
- Reset abort: assert rst asynchronously (mid-cycle) during SHIFT of a Cnt=10 request -> Out=0, done=0, ready=1 immediately; no done pulse after release.
- Random compare: 1000 random In/Cnt/Op against a reference model -> every done cycle matches; Out is stable while done=0.
